// File: rtl/sq_pkg.sv
// Shared definitions for the sum-of-squares accumulator: FSM state
// encoding, square width and the largest legal square value.
package sq_pkg;

  localparam int SQ_W = 8;
  localparam logic [SQ_W-1:0] SQ_MAX = 8'd225;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Larger of two squares, used for the running max of a set.
  function automatic logic [SQ_W-1:0] sq_max_of(input logic [SQ_W-1:0] a,
                                                 input logic [SQ_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sq_accum_if.sv
// Sample-in / result-out handshake bundle for sq_accum.
// master = producer/consumer side, slave = the accumulator.
interface sq_accum_if import sq_pkg::*; #(
  parameter int SUM_W = 12
);

  logic             in_valid;
  logic             in_ready;
  logic [SQ_W-1:0]  square;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum;
  logic [SQ_W-1:0]  max_sq;
  logic             ovf;

  modport master (
    output in_valid, square, out_ready,
    input  in_ready, out_valid, sum, max_sq, ovf
  );

  modport slave (
    input  in_valid, square, out_ready,
    output in_ready, out_valid, sum, max_sq, ovf
  );

endinterface

// File: rtl/sq_accum_add.sv
// SUM_W-bit accumulator adder with carry-out overflow detection.
// Optional saturation: define SQ_ACCUM_SAT_EN to clamp at 2^SUM_W-1,
// otherwise the sum wraps modulo 2^SUM_W. ovf is the same either way.
module sq_accum_add import sq_pkg::*; #(
  parameter int SUM_W = 12
) (
  input  logic [SUM_W-1:0] a,
  input  logic [SQ_W-1:0]  b,
  output logic [SUM_W-1:0] s,
  output logic             ovf
);

  logic [SUM_W:0] full;

  // One extra bit catches any true result above 2^SUM_W-1.
  always_comb begin
    full = {1'b0, a} + (SUM_W + 1)'(b);
    ovf  = full[SUM_W];
`ifdef SQ_ACCUM_SAT_EN
    s    = full[SUM_W] ? {SUM_W{1'b1}} : full[SUM_W-1:0];
`else
    s    = full[SUM_W-1:0];
`endif
  end

endmodule

// File: rtl/sq_accum.sv
// Sum-of-squares accumulator: sums N_SAMPLES accepted squares, tracks the
// largest one and a sticky overflow flag, then holds the result until the
// consumer takes it. Optional macro SQ_ACCUM_SAT_EN selects saturation
// instead of wrap-around in the adder.
module sq_accum import sq_pkg::*; #(
  parameter int N_SAMPLES = 4,
  parameter int SUM_W     = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  sq_accum_if.slave      bus
);

  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SQ_W-1:0]  max_sq_q, max_sq_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [SUM_W-1:0] add_s;
  logic             add_ovf;
  logic             accept;
  logic             handshake;

  sq_accum_add #(.SUM_W(SUM_W)) u_add (
    .a   (sum_q),
    .b   (bus.square),
    .s   (add_s),
    .ovf (add_ovf)
  );

  assign accept    = bus.in_valid & in_ready_q;
  assign handshake = out_valid_q & bus.out_ready;

  // Next-state logic; clear outranks both sample accept and output handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    max_sq_d = max_sq_q;
    ovf_d    = ovf_q;

    if (clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sum_d    = '0;
      max_sq_d = '0;
      ovf_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sum_d    = SUM_W'(bus.square);
            max_sq_d = bus.square;
            cnt_d    = CNT_W'(1);
            ovf_d    = 1'b0;
            state_d  = (N_SAMPLES == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_d    = add_s;
            max_sq_d = sq_max_of(max_sq_q, bus.square);
            cnt_d    = cnt_q + CNT_W'(1);
            ovf_d    = ovf_q | add_ovf;
            if (cnt_q == CNT_W'(N_SAMPLES - 1)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (handshake) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    out_valid_d = (state_d == HOLD);
    in_ready_d  = (state_d != HOLD);
  end

  // State and registered outputs; reset drops any partial set immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sum_q       <= '0;
      max_sq_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      max_sq_q    <= max_sq_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.max_sq    = max_sq_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_sq_accum.sv
// Testbench for sq_accum: two instances (SUM_W=12 and SUM_W=9, N_SAMPLES=4)
// driven in lockstep, checked every cycle against a queue-based model of
// the current set. Directed scenarios first, then randomized traffic.
module tb_sq_accum;

  logic clk;
  logic rst_n;
  logic clear;

  int vecCount;
  int errCount;

  // Model: samples of the current/last set, whether a result is pending,
  // and whether the next accept starts a fresh set.
  int q[$];
  bit holding;
  bit setDone;

  sq_accum_if #(.SUM_W(12)) bus12 ();
  sq_accum_if #(.SUM_W(9))  bus9 ();

  sq_accum #(.N_SAMPLES(4), .SUM_W(12)) dut12 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus12.slave)
  );

  sq_accum #(.N_SAMPLES(4), .SUM_W(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus9.slave)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int modelTotal();
    int t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  function automatic int modelSum(input int w);
    int t   = modelTotal();
    int lim = (1 << w) - 1;
`ifdef SQ_ACCUM_SAT_EN
    return (t > lim) ? lim : t;
`else
    return t % (1 << w);
`endif
  endfunction

  function automatic int modelMax();
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic int modelOvf(input int w);
    return (modelTotal() > ((1 << w) - 1)) ? 1 : 0;
  endfunction

  task automatic modelReset();
    q.delete();
    holding = 1'b0;
    setDone = 1'b0;
  endtask

  // Apply one clock edge worth of inputs to the model.
  task automatic modelStep(input bit c, input bit v, input int sq, input bit ordy);
    if (c) begin
      q.delete();
      holding = 1'b0;
      setDone = 1'b0;
    end else if (holding) begin
      if (ordy) holding = 1'b0;
    end else if (v) begin
      if (setDone) begin
        q.delete();
        setDone = 1'b0;
      end
      q.push_back(sq);
      if (q.size() == 4) begin
        holding = 1'b1;
        setDone = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("in_ready12",  32'(bus12.in_ready),  32'(!holding));
    checkOutput("out_valid12", 32'(bus12.out_valid), 32'(holding));
    checkOutput("sum12",       32'(bus12.sum),       32'(modelSum(12)));
    checkOutput("max12",       32'(bus12.max_sq),    32'(modelMax()));
    checkOutput("ovf12",       32'(bus12.ovf),       32'(modelOvf(12)));
    checkOutput("in_ready9",   32'(bus9.in_ready),   32'(!holding));
    checkOutput("out_valid9",  32'(bus9.out_valid),  32'(holding));
    checkOutput("sum9",        32'(bus9.sum),        32'(modelSum(9)));
    checkOutput("max9",        32'(bus9.max_sq),     32'(modelMax()));
    checkOutput("ovf9",        32'(bus9.ovf),        32'(modelOvf(9)));
  endtask

  // Drive one cycle of inputs, step past the edge, update model and check.
  task automatic applyStimulus(input bit c, input bit v, input int sq, input bit ordy);
    clear           = c;
    bus12.in_valid  = v;
    bus9.in_valid   = v;
    bus12.square    = 8'(sq);
    bus9.square     = 8'(sq);
    bus12.out_ready = ordy;
    bus9.out_ready  = ordy;
    @(posedge clk);
    modelStep(c, v, sq, ordy);
    #1;
    checkAll();
  endtask

  initial begin
    int t1[4] = '{1, 4, 9, 16};
    int t4[4] = '{0, 1, 4, 9};
    int t5[4] = '{49, 36, 25, 16};

    vecCount = 0;
    errCount = 0;
    modelReset();

    rst_n = 1'b0;
    applyStimulusIdle();
    #12;
    checkAll();
    rst_n = 1'b1;
    #1;
    checkAll();

    $display("[TB] test 1: 1,4,9,16 back-to-back");
    foreach (t1[i]) applyStimulus(1'b0, 1'b1, t1[i], 1'b1);
    checkOutput("t1_sum", 32'(bus12.sum), 32'd30);
    checkOutput("t1_max", 32'(bus12.max_sq), 32'd16);
    checkOutput("t1_valid", 32'(bus12.out_valid), 32'd1);
    applyStimulus(1'b0, 1'b1, 200, 1'b1);
    checkOutput("t1_idle_sum", 32'(bus12.sum), 32'd30);

    $display("[TB] test 2: four samples of 225");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 225, 1'b0);
    checkOutput("t2_ovf9", 32'(bus9.ovf), 32'd1);
`ifdef SQ_ACCUM_SAT_EN
    checkOutput("t2_sum9", 32'(bus9.sum), 32'd511);
`else
    checkOutput("t2_sum9", 32'(bus9.sum), 32'd388);
`endif
    checkOutput("t2_sum12", 32'(bus12.sum), 32'd900);

    $display("[TB] test 3: backpressure");
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, $urandom_range(0, 225), 1'b0);
    applyStimulus(1'b0, 1'b1, 7, 1'b1);
    checkOutput("t3_in_ready", 32'(bus12.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, $urandom_range(0, 225), 1'b1);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);

    $display("[TB] test 4: clear mid-set");
    applyStimulus(1'b0, 1'b1, 9, 1'b0);
    applyStimulus(1'b0, 1'b1, 64, 1'b0);
    applyStimulus(1'b1, 1'b1, 100, 1'b1);
    foreach (t4[i]) applyStimulus(1'b0, 1'b1, t4[i], 1'b0);
    checkOutput("t4_sum", 32'(bus12.sum), 32'd14);
    checkOutput("t4_max", 32'(bus12.max_sq), 32'd9);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);

    $display("[TB] test 5: async reset in HOLD");
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, $urandom_range(0, 225), 1'b0);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll();
    @(posedge clk);
    #2;
    checkAll();
    rst_n = 1'b1;
    foreach (t5[i]) applyStimulus(1'b0, 1'b1, t5[i], 1'b0);
    checkOutput("t5_sum", 32'(bus12.sum), 32'd126);
    checkOutput("t5_max", 32'(bus12.max_sq), 32'd49);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      bit c    = ($urandom_range(0, 31) == 0);
      bit v    = ($urandom_range(0, 3) != 0);
      int sq   = ($urandom_range(0, 3) == 0) ? 225 : int'($urandom_range(0, 225));
      bit ordy = ($urandom_range(0, 2) != 0);
      applyStimulus(c, v, sq, ordy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  // Quiet input values used while the block sits in reset.
  task automatic applyStimulusIdle();
    clear           = 1'b0;
    bus12.in_valid  = 1'b0;
    bus9.in_valid   = 1'b0;
    bus12.square    = 8'd0;
    bus9.square     = 8'd0;
    bus12.out_ready = 1'b0;
    bus9.out_ready  = 1'b0;
  endtask

endmodule

// File: doc/sq_accum.md
SQ_ACCUM -- requirements
Module: sq_accum

Interface
REQ-001 The block SHALL have parameter N_SAMPLES, default 4, giving the number of squares summed per result (legal range 1..256).
REQ-002 The block SHALL have parameter SUM_W, default 12, giving the accumulator and result width in bits (legal range 8..32).
REQ-003 Port clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port clear  input  1  SHALL be a synchronous abort that discards the set in progress.
REQ-006 Port in_valid  input  1  SHALL indicate that square holds a valid sample.
REQ-007 Port square  input  8  SHALL carry the unsigned squarer output, range 0..225.
REQ-008 Port in_ready  output  1  SHALL indicate that the block accepts a sample this cycle.
REQ-009 Port out_valid  output  1  SHALL indicate that sum, max_sq and ovf hold a completed result.
REQ-010 Port out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-011 Port sum  output  SUM_W  SHALL carry the sum of N_SAMPLES accepted squares.
REQ-012 Port max_sq  output  8  SHALL carry the largest square in the current set.
REQ-013 Port ovf  output  1  SHALL be a sticky flag, set when the current set overflowed SUM_W bits.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-015 A sample SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-017 On accept in IDLE, the block SHALL load sum=square, max_sq=square, cnt=1, ovf=0, then go to ACCUM, or to HOLD if N_SAMPLES=1.
REQ-018 On accept in ACCUM, the block SHALL set sum to sum+square, max_sq to max(max_sq,square), and cnt to cnt+1.
REQ-019 The accept that brings cnt to N_SAMPLES SHALL move the FSM to HOLD, with out_valid=1 starting the next cycle (latency 1 cycle from the final accept).
REQ-020 In HOLD, sum, max_sq, ovf and out_valid SHALL remain stable until out_valid and out_ready are both 1.
REQ-021 On the output handshake, the FSM SHALL go to IDLE, with out_valid=0 and in_ready=1 the next cycle.
REQ-022 No sample SHALL be accepted in the cycle of the output handshake.
REQ-023 If out_ready=1 while out_valid=0, the block SHALL take no action.
REQ-024 An addition whose true result exceeds 2^SUM_W-1 SHALL set ovf, which SHALL stay set until the next set starts.
REQ-025 clear=1 SHALL force IDLE and zero sum, max_sq, cnt, ovf and out_valid on the next edge, from any state.
REQ-026 clear SHALL have priority over any accept or output handshake in the same cycle.
REQ-027 Between results in IDLE, sum and max_sq SHALL hold their last values.

Reset
REQ-028 When rst_n=0, the block SHALL immediately force state=IDLE, cnt=0, sum=0, max_sq=0, ovf=0 and out_valid=0, without waiting for a clock edge.
REQ-029 in_ready SHALL be 1 while rst_n=0 is asserted and after it is released.
REQ-030 A reset asserted mid-set or in HOLD SHALL discard all partial data.

Configuration
REQ-031 With SQ_ACCUM_SAT_EN defined, an overflowing addition SHALL clamp sum to 2^SUM_W-1, and further additions SHALL leave it clamped.
REQ-032 Without SQ_ACCUM_SAT_EN, sum SHALL wrap modulo 2^SUM_W.
REQ-033 ovf SHALL behave identically whether or not SQ_ACCUM_SAT_EN is defined.

Structure
REQ-034 The shared package sq_pkg SHALL hold the FSM state encoding (IDLE, ACCUM, HOLD), SQ_W=8, and the SQ_MAX=225 constant.
REQ-035 One sub-module, sq_accum_add, SHALL implement the SUM_W-bit add with overflow detection and the optional saturation.

Verification
REQ-036 Test 1 (N_SAMPLES=4, SUM_W=12): feed squares 1,4,9,16 back-to-back with out_ready=1 -> out_valid=1 one cycle after the 4th accept, sum=30, max_sq=16, ovf=0.
REQ-037 Test 2 (overflow, SUM_W=9): feed four samples of 225 -> ovf=1; sum=388 without SQ_ACCUM_SAT_EN, sum=511 with it.
REQ-038 Test 3 (backpressure): complete a set, hold out_ready=0 for 5 cycles -> sum/max_sq stable and in_ready=0 throughout; raise out_ready -> IDLE next cycle.
REQ-039 Test 4 (clear): after 2 accepts (9, 64), pulse clear, then feed 0,1,4,9 -> sum=14, max_sq=9.
REQ-040 Test 5 (reset mid-operation): assert rst_n=0 between clock edges while in HOLD -> out_valid=0 and sum=0 immediately; after release, set 49,36,25,16 -> sum=126, max_sq=49.
